controlador_entrada_saida: RTL and testbench
============================================

# controlador_entrada_saida

Multicycle sequencer for the CPU's switch-input (IN, opcode 19) and display-output (OUT, opcode 20) instructions. It freezes the program counter while an I/O instruction waits for the operator's enter key, then releases it with a single-cycle write or acknowledge. The CPU therefore runs from one free-running clock and no longer switches clock sources. It sits between the instruction decoder, the `enter`/switch inputs, the register-bank write enable, the PC enable and the display number splitter.

## Interface
- `OPCODE_IN`, default 5'd19: opcode that reads the switches into a register.
- `OPCODE_OUT`, default 5'd20: opcode that shows a register value on the display.
- `DEBOUNCE_CICLOS`, default 4: consecutive stable cycles required to accept an enter level change. Range ≥ 2. Synthesis sets it to about 1 000 000.
- `clock`  in  1: single system clock. Every register in the block uses this one clock.
- `reset`  in  1: asynchronous, active-low reset.
- `opcode`  in  5: opcode of the current instruction.
- `enter`  in  1: raw pushbutton, active-low (0 = pressed), asynchronous to `clock`.
- `entradaSwitch`  in  9: two's-complement value on the switches.
- `dadoSaida`  in  32: register value selected for output (bank read port 1).
- `pcHabilita`  out  1: PC may advance on the next edge.
- `bancoEscrita`  out  1: one-cycle write strobe for the IN destination register.
- `dadoEntrada`  out  32: latched, sign-extended switch value.
- `displayValor`  out  32: latched value for the display.
- `displayValido`  out  1: `displayValor` holds a value from an OUT instruction.
- `esperandoEntrada`  out  1: block is waiting for enter on an IN instruction (LED).
- `esperandoSaida`  out  1: block is waiting for enter on an OUT instruction (LED).

## Operation
- **Enter synchroniser.** `enter` is inverted, then passes through two flops `s1` → `s2`. Reset value of both flops is 0 (released).
- **Debouncer.**
  - Counter `cnt` tracks cycles where `s2` differs from the filtered level `f`.
  - `cnt` clears whenever `s2 == f`.
  - When `s2 != f` and `cnt == DEBOUNCE_CICLOS-1`: `f <= s2` and `cnt <= 0`.
  - Flop `fAnt <= f`.
  - Press event `evento = f & ~fAnt` is exactly one cycle wide. A held button produces no further events. Releases produce no event.
- **FSM states:** EXECUTA, ESPERA_ENTER, CONCLUI. Reset state is EXECUTA.
- **EXECUTA.**
  - `pcHabilita = 1` unless `opcode` is IN or OUT. In that case `pcHabilita = 0` combinationally in the same cycle (Mealy).
  - On IN or OUT: go to ESPERA_ENTER and latch flag `opIn <= (opcode == OPCODE_IN)`.
  - If the opcode is OUT, also latch `displayValor <= dadoSaida` and set `displayValido <= 1`.
  - An `evento` while in EXECUTA is discarded and not remembered.
- **ESPERA_ENTER.**
  - `pcHabilita = 0`.
  - `esperandoEntrada = opIn`, `esperandoSaida = ~opIn`.
  - On `evento`: if `opIn`, latch `dadoEntrada <= {{23{entradaSwitch[8]}}, entradaSwitch}`. In both cases go to CONCLUI.
- **CONCLUI.**
  - `pcHabilita = 1` and `bancoEscrita = opIn`, for exactly one cycle.
  - Then go to EXECUTA.
  - `evento` is ignored in this state.
- **Outputs outside their asserting states.**
  - `bancoEscrita` is 0 in every state except CONCLUI.
  - `esperandoEntrada` and `esperandoSaida` are 0 outside ESPERA_ENTER.
- **Held values.**
  - `dadoEntrada` holds until the next IN completes.
  - `displayValor` and `displayValido` hold until the next OUT overwrites them.
- **Opcode changes while waiting.** The latched `opIn` alone decides the CONCLUI action.
- **Back-to-back I/O instructions.** The second is detected in EXECUTA on the cycle after CONCLUI. It needs a new press, because the previous press is not reused.

## Timing
- **Reset.** Asserting `reset` (0) asynchronously forces:
  - state EXECUTA;
  - `s1`, `s2`, `f`, `fAnt`, `cnt`, `opIn` = 0;
  - `dadoEntrada` = 0, `displayValor` = 0, `displayValido` = 0, `bancoEscrita` = 0;
  - `esperandoEntrada` = 0, `esperandoSaida` = 0.
  
  `pcHabilita` is combinational: during reset it is 1 unless `opcode` is IN or OUT.
- **Reset mid-wait.** Returns to EXECUTA with no register write. A button still held after reset is released gives no event until it is released and pressed again.
- **Press latency.** Let E0 be the first `clock` edge that samples `enter` = 0, with `enter` then held stable.
  - `s2` = 1 after edge E0+1.
  - `f` = 1 after edge E0+1+D, where D = `DEBOUNCE_CICLOS`.
  - `evento` is high in the cycle that follows.
  - The FSM enters CONCLUI at edge E0+2+D.
  - The PC advances and the bank writes at edge E0+3+D.
- **Glitch filtering.** Any `s2` pulse shorter than D cycles leaves `f` unchanged.
- **Minimum occupancy.** An I/O instruction occupies at least 3 cycles: EXECUTA, at least one ESPERA_ENTER cycle, and CONCLUI.

## Test plan
- **Reset values.** Hold `reset` = 0 for 3 cycles with `opcode` = 0. Every registered output must be 0 and `pcHabilita` = 1. Then set `opcode` = 19: `pcHabilita` must be 0 with no clock edge.
- **IN instruction.** D = 4, `opcode` = 19, `entradaSwitch` = 9'h1F6 (−10). Press `enter` first sampled at E0.
  - `bancoEscrita` = 1 only in the cycle after edge E0+6.
  - `dadoEntrada` = 32'hFFFFFFF6.
  - `pcHabilita` = 1 only in that same cycle.
- **OUT instruction.** `opcode` = 20, `dadoSaida` = 123.
  - On the cycle after entry: `displayValor` = 123, `displayValido` = 1, `esperandoSaida` = 1.
  - Press enter: `pcHabilita` pulses once and `bancoEscrita` stays 0.
- **Bounce rejection.** Toggle `enter` low for 3 cycles, then high, repeated 5 times, with D = 4. The FSM must stay in ESPERA_ENTER and `pcHabilita` must stay 0.
- **Held button.** Keep `enter` held across two consecutive IN instructions. Exactly one write occurs. The second IN waits until a release and a fresh press.
- **Reset during wait.** Pull `reset` low while in ESPERA_ENTER on an IN, with a press in progress. There must be no `bancoEscrita` pulse, `dadoEntrada` must equal 0, and the state must be EXECUTA.

Source files
------------

// File: rtl/controlador_entrada_saida.sv
// controlador_entrada_saida
//
// Multicycle sequencer for the CPU's IN (read switches into a register) and
// OUT (show a register on the display) instructions. While an I/O
// instruction waits for the operator's enter key, the PC is frozen. Once a
// debounced press arrives, the block releases the PC for one cycle and, on
// IN, pulses the register-bank write enable. The whole CPU runs from one
// free-running clock.
//
// Ports
//   clock            system clock (every register uses it)
//   reset            asynchronous, active-low reset
//   opcode[4:0]      opcode of the current instruction
//   enter            raw pushbutton, active-low, asynchronous to clock
//   entradaSwitch    two's-complement switch value (9 bits)
//   dadoSaida        register value selected for output (bank read port 1)
//   pcHabilita       PC may advance on the next edge (combinational)
//   bancoEscrita     one-cycle write strobe for the IN destination register
//   dadoEntrada      latched, sign-extended switch value
//   displayValor     latched value for the display
//   displayValido    displayValor holds a value from an OUT instruction
//   esperandoEntrada waiting for enter on an IN instruction (LED)
//   esperandoSaida   waiting for enter on an OUT instruction (LED)
//   estadoDebug      current FSM state: 0 EXECUTA, 1 ESPERA_ENTER, 2 CONCLUI
//
// Handshake: there is no valid/ready pair here. The "request" is an IN/OUT
// opcode seen in EXECUTA, and the "acceptance" is the single CONCLUI cycle
// where pcHabilita=1 (and bancoEscrita=1 on IN). The decoder must hold the
// instruction until that cycle.
module controlador_entrada_saida #(
  parameter logic [4:0] OPCODE_IN       = 5'd19,
  parameter logic [4:0] OPCODE_OUT      = 5'd20,
  parameter int         DEBOUNCE_CICLOS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic        enter,
  input  logic [8:0]  entradaSwitch,
  input  logic [31:0] dadoSaida,
  output logic        pcHabilita,
  output logic        bancoEscrita,
  output logic [31:0] dadoEntrada,
  output logic [31:0] displayValor,
  output logic        displayValido,
  output logic        esperandoEntrada,
  output logic        esperandoSaida,
  output logic [1:0]  estadoDebug
);

  // $clog2(D) bits are enough to hold the terminal count D-1.
  localparam int            CW      = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    EXECUTA      = 2'd0,
    ESPERA_ENTER = 2'd1,
    CONCLUI      = 2'd2
  } estadoT;

  estadoT        estado;
  logic          s1, s2, f, fAnt;
  logic [CW-1:0] cnt;
  logic          opIn;
  logic          evento;
  logic          ehIo;

  // Synchroniser and debouncer. The button is active-low, so it is inverted
  // before the first flop; s2 is therefore 1 while pressed. f follows s2 only
  // after s2 has disagreed with it for DEBOUNCE_CICLOS consecutive cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      f    <= 1'b0;
      fAnt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= ~enter;
      s2   <= s1;
      fAnt <= f;
      if (s2 == f) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        f   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Rising edge of the filtered level: one cycle per press, none on release.
  assign evento = f & ~fAnt;
  assign ehIo   = (opcode == OPCODE_IN) || (opcode == OPCODE_OUT);

  // Sequencer. All outputs except pcHabilita are registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado           <= EXECUTA;
      opIn             <= 1'b0;
      dadoEntrada      <= '0;
      displayValor     <= '0;
      displayValido    <= 1'b0;
      bancoEscrita     <= 1'b0;
      esperandoEntrada <= 1'b0;
      esperandoSaida   <= 1'b0;
    end else begin
      case (estado)
        EXECUTA: begin
          // A press seen here is simply dropped; the next I/O needs a new one.
          if (ehIo) begin
            estado           <= ESPERA_ENTER;
            opIn             <= (opcode == OPCODE_IN);
            esperandoEntrada <= (opcode == OPCODE_IN);
            esperandoSaida   <= (opcode != OPCODE_IN);
            if (opcode == OPCODE_OUT) begin
              displayValor  <= dadoSaida;
              displayValido <= 1'b1;
            end
          end
        end
        ESPERA_ENTER: begin
          // Only the latched opIn matters from here on, even if the opcode
          // input changes while waiting.
          if (evento) begin
            if (opIn) begin
              dadoEntrada <= {{23{entradaSwitch[8]}}, entradaSwitch};
            end
            bancoEscrita     <= opIn;
            esperandoEntrada <= 1'b0;
            esperandoSaida   <= 1'b0;
            estado           <= CONCLUI;
          end
        end
        CONCLUI: begin
          bancoEscrita <= 1'b0;
          estado       <= EXECUTA;
        end
        default: begin
          bancoEscrita     <= 1'b0;
          esperandoEntrada <= 1'b0;
          esperandoSaida   <= 1'b0;
          estado           <= EXECUTA;
        end
      endcase
    end
  end

  // Mealy PC enable: an I/O opcode freezes the PC in the same cycle it
  // appears, so the instruction is never skipped.
  always_comb begin
    pcHabilita = 1'b0;
    case (estado)
      EXECUTA:      pcHabilita = ~ehIo;
      ESPERA_ENTER: pcHabilita = 1'b0;
      CONCLUI:      pcHabilita = 1'b1;
      default:      pcHabilita = 1'b0;
    endcase
  end

  assign estadoDebug = estado;

endmodule

// File: tb/tb_controlador_entrada_saida.sv
module tb_controlador_entrada_saida;

  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic        enter = 1'b1;
  logic [8:0]  entradaSwitch = 9'd0;
  logic [31:0] dadoSaida = 32'd0;
  logic        pcHabilita, bancoEscrita, displayValido;
  logic        esperandoEntrada, esperandoSaida;
  logic [31:0] dadoEntrada, displayValor;
  logic [1:0]  estadoDebug;

  controlador_entrada_saida #(
    .OPCODE_IN(5'd19), .OPCODE_OUT(5'd20), .DEBOUNCE_CICLOS(D)
  ) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .enter(enter),
    .entradaSwitch(entradaSwitch), .dadoSaida(dadoSaida),
    .pcHabilita(pcHabilita), .bancoEscrita(bancoEscrita),
    .dadoEntrada(dadoEntrada), .displayValor(displayValor),
    .displayValido(displayValido), .esperandoEntrada(esperandoEntrada),
    .esperandoSaida(esperandoSaida), .estadoDebug(estadoDebug)
  );

  int edgeCnt = 0;
  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Button path: two-cycle delay, then the filtered level flips once the
  // last D delayed samples all disagree with it.
  // Instruction path: phase 0 = running, 1 = waiting for a press,
  // 2 = the single release cycle.
  bit          mS1, mS2, mF, mFAnt;
  bit          janela[$];
  int          mPhase;
  bit          mOpIn;
  logic [31:0] mDadoE, mDisp;
  bit          mValido;

  task automatic passoModelo();
    bit ev, flip;
    if (!reset) begin
      mS1 = 0; mS2 = 0; mF = 0; mFAnt = 0; janela.delete();
      mPhase = 0; mOpIn = 0; mDadoE = 0; mDisp = 0; mValido = 0;
    end else begin
      ev = mF && !mFAnt;
      janela.push_back(mS2);
      if (janela.size() > D) void'(janela.pop_front());
      flip = (janela.size() == D);
      foreach (janela[i]) if (janela[i] == mF) flip = 0;
      mFAnt = mF;
      if (flip) begin
        mF = !mF;
        janela.delete();
      end
      mS2 = mS1;
      mS1 = !enter;
      if (mPhase == 0) begin
        if (opcode == 5'd19 || opcode == 5'd20) begin
          mOpIn  = (opcode == 5'd19);
          mPhase = 1;
          if (opcode == 5'd20) begin
            mDisp   = dadoSaida;
            mValido = 1;
          end
        end
      end else if (mPhase == 1) begin
        if (ev) begin
          if (mOpIn) mDadoE = 32'($signed(entradaSwitch));
          mPhase = 2;
        end
      end else begin
        mPhase = 0;
      end
    end
  endtask

  task automatic conferirSaidas();
    bit io;
    logic espPc;
    io = (opcode == 5'd19 || opcode == 5'd20);
    espPc = (mPhase == 0) ? !io : (mPhase == 2);
    confere("pcHabilita", 32'(pcHabilita), 32'(espPc));
    confere("bancoEscrita", 32'(bancoEscrita), 32'(mPhase == 2 && mOpIn));
    confere("esperandoEntrada", 32'(esperandoEntrada), 32'(mPhase == 1 && mOpIn));
    confere("esperandoSaida", 32'(esperandoSaida), 32'(mPhase == 1 && !mOpIn));
    confere("dadoEntrada", dadoEntrada, mDadoE);
    confere("displayValor", displayValor, mDisp);
    confere("displayValido", 32'(displayValido), 32'(mValido));
    confere("estado", 32'(estadoDebug), 32'(mPhase));
  endtask

  // ---------------- driver ----------------
  // Caller sets inputs at a negedge, then calls ciclo: the model consumes
  // those inputs, the DUT sees them at the posedge, and outputs are compared
  // at the following negedge.
  task automatic ciclo();
    passoModelo();
    @(negedge clock);
    conferirSaidas();
  endtask

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  // Runs until a bank write is observed or the budget expires.
  task automatic esperaEscrita(input int budget, output int edgeVisto);
    edgeVisto = -1;
    for (int i = 0; i < budget && edgeVisto < 0; i++) begin
      ciclo();
      if (bancoEscrita) edgeVisto = edgeCnt;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0, wEdge, escritas, pcPulsos, runLen;

    // Reset values.
    reset = 0; opcode = 0;
    ciclos(3);
    confere("rst_banco", 32'(bancoEscrita), 32'd0);
    confere("rst_pc", 32'(pcHabilita), 32'd1);
    opcode = 5'd19;
    #1;
    confere("rst_pc_mealy", 32'(pcHabilita), 32'd0);
    opcode = 0;
    @(negedge clock);
    reset = 1;
    ciclos(2);

    // IN instruction, latency from first sampled press.
    opcode = 5'd19; entradaSwitch = 9'h1F6;
    ciclos(2);
    enter = 0;
    e0 = edgeCnt + 1;
    esperaEscrita(30, wEdge);
    confere("in_latency", 32'(wEdge), 32'(e0 + 6));
    confere("in_dado", dadoEntrada, 32'hFFFF_FFF6);
    opcode = 0;
    ciclo();
    enter = 1;
    ciclos(D + 4);

    // OUT instruction.
    opcode = 5'd20; dadoSaida = 32'd123;
    ciclo();
    confere("out_valor", displayValor, 32'd123);
    confere("out_valido", 32'(displayValido), 32'd1);
    confere("out_esperando", 32'(esperandoSaida), 32'd1);
    enter = 0;
    pcPulsos = 0; escritas = 0;
    for (int i = 0; i < 15; i++) begin
      ciclo();
      if (i == 0) opcode = 0;
      if (pcHabilita && estadoDebug == 2'd2) pcPulsos++;
      if (bancoEscrita) escritas++;
    end
    confere("out_pc_pulsos", 32'(pcPulsos), 32'd1);
    confere("out_sem_escrita", 32'(escritas), 32'd0);
    enter = 1;
    ciclos(D + 4);

    // Bounce rejection.
    opcode = 5'd19; entradaSwitch = 9'h055;
    ciclo();
    pcPulsos = 0;
    for (int r = 0; r < 5; r++) begin
      enter = 0;
      for (int i = 0; i < 3; i++) begin ciclo(); if (pcHabilita) pcPulsos++; end
      enter = 1;
      for (int i = 0; i < 3; i++) begin ciclo(); if (pcHabilita) pcPulsos++; end
    end
    confere("bounce_pc", 32'(pcPulsos), 32'd0);
    confere("bounce_espera", 32'(esperandoEntrada), 32'd1);
    enter = 0;
    esperaEscrita(30, wEdge);
    confere("bounce_final", 32'(wEdge >= 0), 32'd1);
    confere("bounce_dado", dadoEntrada, 32'h0000_0055);

    // Held button across two consecutive IN instructions.
    opcode = 5'd19; entradaSwitch = 9'h003;
    escritas = 0;
    for (int i = 0; i < 30; i++) begin ciclo(); if (bancoEscrita) escritas++; end
    confere("held_sem_escrita", 32'(escritas), 32'd0);
    confere("held_espera", 32'(esperandoEntrada), 32'd1);
    enter = 1;
    for (int i = 0; i < D + 4; i++) begin ciclo(); if (bancoEscrita) escritas++; end
    confere("held_release", 32'(escritas), 32'd0);
    enter = 0;
    esperaEscrita(30, wEdge);
    confere("held_nova", 32'(wEdge >= 0), 32'd1);
    confere("held_dado", dadoEntrada, 32'h0000_0003);
    opcode = 0;
    ciclo();
    enter = 1;
    ciclos(D + 4);

    // Reset during a wait with a press in progress.
    opcode = 5'd19; entradaSwitch = 9'h100;
    ciclos(2);
    enter = 0;
    ciclos(2);
    reset = 0; enter = 1; opcode = 0;
    escritas = 0;
    for (int i = 0; i < 3; i++) begin ciclo(); if (bancoEscrita) escritas++; end
    reset = 1;
    for (int i = 0; i < D + 6; i++) begin ciclo(); if (bancoEscrita) escritas++; end
    confere("rstw_escrita", 32'(escritas), 32'd0);
    confere("rstw_dado", dadoEntrada, 32'd0);
    confere("rstw_estado", 32'(estadoDebug), 32'd0);

    // Randomised traffic against the model.
    runLen = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: opcode = 5'd19;
          1: opcode = 5'd20;
          default: opcode = 5'($urandom_range(0, 31));
        endcase
      end
      if (runLen == 0) begin
        enter  = $urandom_range(0, 1);
        runLen = $urandom_range(1, 3 * D);
      end else begin
        runLen--;
      end
      entradaSwitch = 9'($urandom);
      dadoSaida     = $urandom;
      reset         = ($urandom_range(0, 199) != 0);
      ciclo();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
